// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/retire, out-of-order completion,
// and a full flush when a mispredicted instruction reaches the head.
package rob_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_SIZE    = 32;
    localparam int ROB_IDX_LEN = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            dispatch_enable;
        logic [4:0]      dest_reg_idx;
    } id_rob_packet_t;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] entry_idx1;
        logic [ROB_IDX_LEN-1:0] entry_idx2;
    } rs_rob_packet_t;

    typedef struct packed {
        logic                   completed;
        logic [ROB_IDX_LEN-1:0] entry_idx;
        logic [XLEN-1:0]        value;
        logic                   mis_pred;
    } fu_rob_packet_t;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_tail;
        logic [XLEN-1:0]        value1;
        logic [XLEN-1:0]        value2;
        logic                   squash;
    } rob_rs_packet_t;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_tail;
        logic                   squash;
    } rob_mt_packet_t;

    typedef struct packed {
        logic            dest_valid;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] dest_value;
    } rob_reg_packet_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] value;
        logic            completed;
        logic            mis_pred;
    } rob_entry_t;
endpackage

module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_SIZE    = rob_pkg::ROB_SIZE,
    parameter int ROB_IDX_LEN = rob_pkg::ROB_IDX_LEN,
    parameter int XLEN        = rob_pkg::XLEN
) (
    input  logic                          clock,
    input  logic                          reset,
    input  id_rob_packet_t                id_rob,
    input  rs_rob_packet_t                rs_rob,
    input  fu_rob_packet_t                fu_rob,
    output logic                          rob_full,
    output rob_rs_packet_t                rob_rs,
    output rob_mt_packet_t                rob_mt,
    output rob_reg_packet_t               rob_reg,
    output logic [ROB_IDX_LEN-1:0]        rob_head,
    output logic [ROB_IDX_LEN-1:0]        rob_tail,
    output logic [ROB_IDX_LEN-1:0]        rob_counter,
    output rob_entry_t [ROB_SIZE-1:0]     rob_entries
);

    rob_entry_t [ROB_SIZE-1:0] entries;
    logic [ROB_IDX_LEN-1:0]    head;
    logic [ROB_IDX_LEN-1:0]    tail;
    logic [ROB_IDX_LEN-1:0]    counter;
    rob_entry_t                head_entry;
    logic                      squash;
    logic                      retire;
    logic                      dispatch;

    function automatic logic [ROB_IDX_LEN-1:0] next_ptr(input logic [ROB_IDX_LEN-1:0] p);
        return (p == ROB_IDX_LEN'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_entry = entries[head];
    assign squash     = head_entry.valid & head_entry.completed & head_entry.mis_pred;
    assign retire     = head_entry.valid & head_entry.completed & ~head_entry.mis_pred;
    assign rob_full   = (counter == ROB_IDX_LEN'(ROB_SIZE - 1));
    // Full is judged before this cycle's retire frees a slot, so dispatch stalls.
    assign dispatch   = id_rob.dispatch_enable & ~rob_full & ~squash;

    assign rob_rs.rob_tail = tail;
    assign rob_rs.value1   = entries[rs_rob.entry_idx1].value;
    assign rob_rs.value2   = entries[rs_rob.entry_idx2].value;
    assign rob_rs.squash   = squash;
    assign rob_mt.rob_tail = tail;
    assign rob_mt.squash   = squash;

    assign rob_reg.dest_valid   = retire;
    assign rob_reg.dest_reg_idx = head_entry.dest_reg_idx;
    assign rob_reg.dest_value   = head_entry.value;

    assign rob_head    = head;
    assign rob_tail    = tail;
    assign rob_counter = counter;
    assign rob_entries = entries;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            counter <= '0;
        end else if (squash) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            counter <= '0;
        end else begin
            if (fu_rob.completed && entries[fu_rob.entry_idx].valid) begin
                entries[fu_rob.entry_idx].completed <= 1'b1;
                entries[fu_rob.entry_idx].value     <= fu_rob.value;
                entries[fu_rob.entry_idx].mis_pred  <= fu_rob.mis_pred;
            end
            if (dispatch) begin
                entries[tail].valid        <= 1'b1;
                entries[tail].pc           <= id_rob.pc;
                entries[tail].dest_reg_idx <= id_rob.dest_reg_idx;
                entries[tail].value        <= '0;
                entries[tail].completed    <= 1'b0;
                entries[tail].mis_pred     <= 1'b0;
                tail                       <= next_ptr(tail);
            end
            // Placed last so invalidation wins over a late completion to the head.
            if (retire) begin
                entries[head].valid <= 1'b0;
                head                <= next_ptr(head);
            end
            case ({dispatch, retire})
                2'b10:   counter <= counter + 1'b1;
                2'b01:   counter <= counter - 1'b1;
                default: counter <= counter;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, completion, retire, squash,
// full/wrap handling and asynchronous reset.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    id_rob_packet_t        id_rob;
    rs_rob_packet_t        rs_rob;
    fu_rob_packet_t        fu_rob;
    logic                  rob_full;
    rob_rs_packet_t        rob_rs;
    rob_mt_packet_t        rob_mt;
    rob_reg_packet_t       rob_reg;
    logic [4:0]            rob_head;
    logic [4:0]            rob_tail;
    logic [4:0]            rob_counter;
    rob_entry_t [31:0]     rob_entries;

    int checks   = 0;
    int failures = 0;

    reorder_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .id_rob      (id_rob),
        .rs_rob      (rs_rob),
        .fu_rob      (fu_rob),
        .rob_full    (rob_full),
        .rob_rs      (rob_rs),
        .rob_mt      (rob_mt),
        .rob_reg     (rob_reg),
        .rob_head    (rob_head),
        .rob_tail    (rob_tail),
        .rob_counter (rob_counter),
        .rob_entries (rob_entries)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dispatch(input logic en, input logic [31:0] pc, input logic [4:0] dest);
        id_rob.dispatch_enable = en;
        id_rob.pc              = pc;
        id_rob.dest_reg_idx    = dest;
    endtask

    task automatic set_complete(input logic en, input logic [4:0] idx, input logic [31:0] val,
                                input logic mp);
        fu_rob.completed = en;
        fu_rob.entry_idx = idx;
        fu_rob.value     = val;
        fu_rob.mis_pred  = mp;
    endtask

    function automatic logic any_valid();
        logic v = 1'b0;
        for (int i = 0; i < 32; i++) v = v | rob_entries[i].valid;
        return v;
    endfunction

    initial begin
        id_rob = '0;
        rs_rob = '0;
        fu_rob = '0;

        // Reset held, then released away from a clock edge
        #12;
        chk("rst_head",    64'(rob_head), 64'd0);
        chk("rst_tail",    64'(rob_tail), 64'd0);
        chk("rst_counter", 64'(rob_counter), 64'd0);
        chk("rst_full",    64'(rob_full), 64'd0);
        chk("rst_rob_rs",  64'(rob_rs.value1 | rob_rs.value2 | 32'(rob_rs.rob_tail) | 32'(rob_rs.squash)), 64'd0);
        chk("rst_rob_mt",  64'(rob_mt), 64'd0);
        chk("rst_rob_reg", 64'(rob_reg), 64'd0);
        chk("rst_valid",   64'(any_valid()), 64'd0);
        reset = 1'b1;
        tick();
        chk("idle_tail", 64'(rob_tail), 64'd0);

        // Two dispatches
        set_dispatch(1'b1, 32'd0, 5'd3);
        tick();
        chk("d1_tail",       64'(rob_tail), 64'd1);
        chk("d1_mt_tail",    64'(rob_mt.rob_tail), 64'd1);
        chk("d1_dest_idx",   64'(rob_reg.dest_reg_idx), 64'd3);
        chk("d1_dest_valid", 64'(rob_reg.dest_valid), 64'd0);
        chk("d1_value1",     64'(rob_rs.value1), 64'd0);
        chk("d1_value2",     64'(rob_rs.value2), 64'd0);
        chk("d1_squash",     64'(rob_rs.squash), 64'd0);
        chk("d1_counter",    64'(rob_counter), 64'd1);
        set_dispatch(1'b1, 32'd1, 5'd2);
        tick();
        chk("d2_tail",       64'(rob_tail), 64'd2);
        chk("d2_dest_idx",   64'(rob_reg.dest_reg_idx), 64'd3);
        chk("d2_dest_valid", 64'(rob_reg.dest_valid), 64'd0);
        chk("d2_e1_pc",      64'(rob_entries[1].pc), 64'd1);
        chk("d2_e1_dest",    64'(rob_entries[1].dest_reg_idx), 64'd2);
        chk("d2_e1_valid",   64'(rob_entries[1].valid), 64'd1);
        set_dispatch(1'b0, 32'd0, 5'd0);

        // Out-of-order completion, then in-order retire
        rs_rob.entry_idx1 = 5'd1;
        rs_rob.entry_idx2 = 5'd0;
        set_complete(1'b1, 5'd1, 32'h9C, 1'b0);
        tick();
        chk("c1_value1",     64'(rob_rs.value1), 64'h9C);
        chk("c1_value2",     64'(rob_rs.value2), 64'd0);
        chk("c1_dest_valid", 64'(rob_reg.dest_valid), 64'd0);
        set_complete(1'b1, 5'd0, 32'h1, 1'b0);
        tick();
        chk("c0_dest_valid", 64'(rob_reg.dest_valid), 64'd1);
        chk("c0_dest_value", 64'(rob_reg.dest_value), 64'd1);
        chk("c0_dest_idx",   64'(rob_reg.dest_reg_idx), 64'd3);
        chk("c0_value2",     64'(rob_rs.value2), 64'd1);
        set_complete(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("r0_dest_valid", 64'(rob_reg.dest_valid), 64'd1);
        chk("r0_dest_idx",   64'(rob_reg.dest_reg_idx), 64'd2);
        chk("r0_dest_value", 64'(rob_reg.dest_value), 64'h9C);
        chk("r0_head",       64'(rob_head), 64'd1);
        chk("r0_counter",    64'(rob_counter), 64'd1);
        tick();
        chk("r1_head",       64'(rob_head), 64'd2);
        chk("r1_tail",       64'(rob_tail), 64'd2);
        chk("r1_counter",    64'(rob_counter), 64'd0);
        chk("r1_dest_valid", 64'(rob_reg.dest_valid), 64'd0);

        // Mispredict at head squashes everything, including same-cycle dispatch
        set_dispatch(1'b1, 32'h40, 5'd7);
        tick();
        chk("sq_pre_tail", 64'(rob_tail), 64'd3);
        set_dispatch(1'b0, 32'd0, 5'd0);
        set_complete(1'b1, 5'd2, 32'h55, 1'b1);
        tick();
        set_complete(1'b0, 5'd0, 32'd0, 1'b0);
        chk("sq_rs_squash",  64'(rob_rs.squash), 64'd1);
        chk("sq_mt_squash",  64'(rob_mt.squash), 64'd1);
        chk("sq_dest_valid", 64'(rob_reg.dest_valid), 64'd0);
        set_dispatch(1'b1, 32'h44, 5'd9);
        tick();
        set_dispatch(1'b0, 32'd0, 5'd0);
        chk("sq_head",    64'(rob_head), 64'd0);
        chk("sq_tail",    64'(rob_tail), 64'd0);
        chk("sq_counter", 64'(rob_counter), 64'd0);
        chk("sq_valid",   64'(any_valid()), 64'd0);
        chk("sq_clear",   64'(rob_rs.squash), 64'd0);

        // Fill to capacity, overflow dispatch, retire one, then wrap
        for (int i = 0; i < 31; i++) begin
            set_dispatch(1'b1, 32'(i), 5'(i));
            tick();
        end
        chk("full_flag",    64'(rob_full), 64'd1);
        chk("full_counter", 64'(rob_counter), 64'd31);
        chk("full_tail",    64'(rob_tail), 64'd31);
        set_dispatch(1'b1, 32'hDEAD, 5'd1);
        tick();
        chk("ovf_tail",    64'(rob_tail), 64'd31);
        chk("ovf_counter", 64'(rob_counter), 64'd31);
        set_complete(1'b1, 5'd0, 32'hAB, 1'b0);
        tick();
        set_complete(1'b0, 5'd0, 32'd0, 1'b0);
        chk("fr_dest_valid", 64'(rob_reg.dest_valid), 64'd1);
        chk("fr_dest_value", 64'(rob_reg.dest_value), 64'hAB);
        chk("fr_full",       64'(rob_full), 64'd1);
        tick();
        chk("fr_counter", 64'(rob_counter), 64'd30);
        chk("fr_full_lo", 64'(rob_full), 64'd0);
        chk("fr_tail",    64'(rob_tail), 64'd31);
        chk("fr_head",    64'(rob_head), 64'd1);
        tick();
        set_dispatch(1'b0, 32'd0, 5'd0);
        chk("wrap_tail",     64'(rob_tail), 64'd0);
        chk("wrap_counter",  64'(rob_counter), 64'd31);
        chk("wrap_e31_pc",   64'(rob_entries[31].pc), 64'hDEAD);
        chk("wrap_e31_vld",  64'(rob_entries[31].valid), 64'd1);

        // Asynchronous reset mid-operation, between clock edges
        #3;
        reset = 1'b0;
        #1;
        chk("ar_counter", 64'(rob_counter), 64'd0);
        chk("ar_head",    64'(rob_head), 64'd0);
        chk("ar_tail",    64'(rob_tail), 64'd0);
        chk("ar_full",    64'(rob_full), 64'd0);
        chk("ar_valid",   64'(any_valid()), 64'd0);
        chk("ar_rob_reg", 64'(rob_reg), 64'd0);
        reset = 1'b1;
        tick();
        chk("ar_post_tail", 64'(rob_tail), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer (`rob`) of the out-of-order core. It allocates one entry per dispatched instruction from decode and tells the reservation stations and map table which tag was allocated. It captures results and mispredict flags from the functional units, supplies operand values to the RS, and retires in program order to the register file. A mispredicted instruction reaching the head squashes the whole pipeline.

## Interface
- `ROB_SIZE`, default 32: number of physical slots; usable capacity is ROB_SIZE-1.
- `ROB_IDX_LEN`, default 5: log2(ROB_SIZE); width of all tags, pointers and the counter.
- `XLEN`, default 32: data/PC width.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `id_rob`  in  ID_ROB_PACKET  {PC[XLEN], dispatch_enable, dest_reg_idx[5]} from decode.
- `rs_rob`  in  RS_ROB_PACKET  {entry_idx1, entry_idx2} operand tags the RS is reading.
- `fu_rob`  in  FU_ROB_PACKET  {completed, entry_idx, value[XLEN], mis_pred} completion broadcast.
- `rob_full`  out  1  no free slot; decode must stall.
- `rob_rs`  out  ROB_RS_PACKET  {rob_tail, value1, value2, squash}.
- `rob_mt`  out  ROB_MT_PACKET  {rob_tail, squash}; always equal to the same fields of rob_rs.
- `rob_reg`  out  ROB_REG_PACKET  {dest_valid, dest_reg_idx[5], dest_value[XLEN]} retire port.
- `rob_head`, `rob_tail`, `rob_counter`  out  ROB_IDX_LEN each  debug: pointers and occupancy.
- `rob_entries`  out  ROB_SIZE x ROB_ENTRY  debug: full entry array.

## Operation
- Each ROB_ENTRY holds {valid, PC, dest_reg_idx, value, completed, mis_pred}.
- Dispatch: if dispatch_enable and !rob_full and !squash, write entries[tail] = {valid=1, PC, dest_reg_idx, value=0, completed=0, mis_pred=0}. Advance tail by 1 modulo ROB_SIZE and increment the counter. Dispatch while full or squashing is dropped silently.
- rob_rs.rob_tail and rob_mt.rob_tail give the current tail register, which is the tag the next dispatched instruction receives.
- Complete: if fu_rob.completed and entries[entry_idx].valid, set completed=1, value=fu_rob.value and mis_pred=fu_rob.mis_pred. Completions to invalid entries are ignored.
- Operand read: value1 = entries[entry_idx1].value and value2 = entries[entry_idx2].value, read combinationally from stored state. There is no bypass of same-cycle completion.
- Retire is combinational from the head entry:
  - dest_reg_idx = entries[head].dest_reg_idx and dest_value = entries[head].value, always, even when not retiring.
  - dest_valid = entries[head].valid & entries[head].completed & !entries[head].mis_pred.
  - On the clock edge the retired entry is invalidated, head advances modulo ROB_SIZE and the counter decrements.
- Squash = entries[head].valid & completed & mis_pred, combinational. It drives rob_rs.squash and rob_mt.squash. The head instruction's own value is not written back. On that edge all entries are cleared, head=tail=counter=0, and that cycle's dispatch and completion are discarded.
- rob_full = (counter == ROB_SIZE-1).
- At most one dispatch, one completion and one retire per cycle.

## Timing
- Reset (reset=0, asynchronous): head=tail=counter=0 and all entries zeroed. Consequently rob_full=0, squash=0, dest_valid=0, dest_reg_idx=0, dest_value=0, value1=value2=0 and rob_tail=0.
- Dispatch in cycle N: rob_tail and rob_counter update after edge N; the entry is visible on rob_entries in cycle N+1.
- Completion in cycle N: value is readable via value1/value2 from cycle N+1. If the entry is at head, dest_valid (or squash) asserts in cycle N+1.
- Retire and squash outputs are combinational within the cycle; the pointer update occurs at the following edge.
- Simultaneous dispatch and retire: counter unchanged, head and tail both advance. Dispatch is accepted when full only if it is not blocked; rob_full is evaluated before the retire, so dispatch stalls that cycle.
- Pointers wrap from ROB_SIZE-1 to 0.

## Test plan
- Reset, then release: head=tail=counter=0, rob_full=0, all packet outputs 0.
- Dispatch PC=0, dest=3, then PC=1, dest=2 on consecutive cycles:
  - After the first edge: rob_tail=1, dest_reg_idx=3, dest_valid=0, value1=value2=0, squash=0.
  - After the second edge: rob_tail=2, dest_reg_idx=3, dest_valid=0.
- Complete entry 1 with value 0x9C, with rs_rob.entry_idx1=1: next cycle value1=0x9C and dest_valid=0 (head is entry 0, not complete). Then complete entry 0 with value 1: next cycle dest_valid=1, dest_value=1, dest_reg_idx=3.
  - Following cycle: dest_valid=1, dest_reg_idx=2, dest_value=0x9C.
  - Then head=tail=2, counter=0.
- Complete the head with mis_pred=1: squash=1 on rob_rs and rob_mt that cycle and dest_valid=0. Next cycle head=tail=counter=0, all entries invalid, and the dispatch asserted during the squash cycle is dropped.
- Dispatch 31 times: rob_full=1 and counter=31. A 32nd dispatch is ignored (tail unchanged). Retire one entry: rob_full drops, and a subsequent dispatch wraps tail to 0.
- Assert reset mid-operation with entries pending: all state clears immediately without waiting for a clock edge.
